// File: rtl/voxel_pkg.sv
// Shared encodings for the voxel renderer: view-axis codes, FSM states, depth shading.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package voxel_pkg;

    // View axis codes; code 3 aliases the front view.
    localparam logic [1:0] MODE_FRONT     = 2'd0;
    localparam logic [1:0] MODE_TOP       = 2'd1;
    localparam logic [1:0] MODE_SIDE      = 2'd2;
    localparam logic [1:0] MODE_FRONT_ALT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_WRITE,
        ST_DONE
    } state_e;

    // Nearer voxels are brighter: depth 0 is 8'hFF, each step darker by 256/GRID.
    function automatic logic [7:0] shade(input int unsigned d, input int unsigned gb);
        logic [7:0] step;
        step = 8'(d << (8 - gb));
        return 8'hFF - step;
    endfunction

endpackage

// File: rtl/voxel_ram.sv
// GRID^3 x 1 voxel bitmap with one write port and one registered read port, power-up zero.
// Latency: read data valid one cycle after the read address is presented.
// Backpressure: none; writes and reads are accepted every cycle.
module voxel_ram #(
    parameter int VW = 9
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [VW-1:0] wr_addr_i,
    input  logic          wr_dat_i,
    input  logic [VW-1:0] rd_addr_i,
    output logic          rd_dat_o
);

    // Contents survive reset on purpose; only the power-up value is defined.
    logic [(1<<VW)-1:0] mem_q = '0;
    logic               rd_dat_q;

    // Bitmap write port and synchronous read port.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
        rd_dat_q <= mem_q[rd_addr_i];
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/voxel_raster.sv
// Projects the voxel grid along the chosen axis and paints depth-shaded CELLxCELL blocks.
// Latency: first framebuffer write 3 cycles after the trigger cycle at the earliest.
// Backpressure: display_on high stalls pixel output (we low, counters/addr hold); scan continues.
module voxel_raster #(
    parameter int GRID       = 8,
    parameter int CELL       = 8,
    parameter int FB_W       = 64,
    parameter int ADDR_W     = 12,
    parameter int START_LINE = 240
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      display_on,
    input  logic [8:0]                hpos,
    input  logic [8:0]                vpos,
    input  logic [1:0]                mode,
    input  logic [7:0]                bg_color,
    input  logic                      vox_we,
    input  logic [3*$clog2(GRID)-1:0] vox_addr,
    input  logic                      vox_din,
    output logic                      vox_ready,
    output logic                      we,
    output logic [ADDR_W-1:0]         addr,
    output logic [7:0]                ram_d,
    output logic                      busy,
    output logic                      frame_done
);
    import voxel_pkg::*;

    localparam int GB   = $clog2(GRID);
    localparam int VW   = 3 * GB;
    localparam int PW   = 2 * $clog2(CELL) + 1;
    localparam logic [GB:0]   DEP_END = (GB+1)'(GRID);
    localparam logic [PW-1:0] PIX_END = PW'(CELL * CELL);
    localparam logic [GB-1:0] COL_MAX = GB'(GRID - 1);

    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [7:0]          bg_q, bg_d;
    logic [GB-1:0]       cx_q, cx_d, cy_q, cy_d;
    logic [GB:0]         dep_q, dep_d;      // next depth to issue
    logic                pend_q, pend_d;    // read data for depth dep_q-1 is valid
    logic [PW-1:0]       pix_q, pix_d;      // pixels of this block already emitted
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          ram_d_q, ram_d_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                rdy_q, rdy_d;

    logic [VW-1:0]       rd_addr;
    logic                rd_bit;
    logic                trigger;
    logic                emit;
    logic [PW-1:0]       emit_idx;

    // Framebuffer byte address of pixel index pix inside column block (cx,cy).
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [GB-1:0] cx,
                                                   input logic [GB-1:0] cy,
                                                   input logic [PW-1:0] pix);
        int unsigned p, px, py, a;
        p  = 32'(pix);
        px = p % CELL;
        py = p / CELL;
        a  = (32'(cy) * CELL + py) * FB_W + 32'(cx) * CELL + px;
        return a[ADDR_W-1:0];
    endfunction

    assign trigger = (vpos == 9'(START_LINE)) && (hpos == 9'd0);

    // Map (column, depth) to a voxel index {x,y,z} for the latched view axis.
    always_comb begin
        rd_addr = '0;
        case (mode_q)
            MODE_TOP:  rd_addr = {cx_q, dep_q[GB-1:0], cy_q};
            MODE_SIDE: rd_addr = {dep_q[GB-1:0], cy_q, cx_q};
            default:   rd_addr = {cx_q, cy_q, dep_q[GB-1:0]};
        endcase
    end

    voxel_ram #(.VW(VW)) u_ram (
        .clk       (clk),
        .wr_en_i   (vox_we && rdy_q),
        .wr_addr_i (vox_addr),
        .wr_dat_i  (vox_din),
        .rd_addr_i (rd_addr),
        .rd_dat_o  (rd_bit)
    );

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        bg_d     = bg_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        dep_d    = dep_q;
        pend_d   = pend_q;
        pix_d    = pix_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        ram_d_d  = ram_d_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        rdy_d    = rdy_q;
        emit     = 1'b0;
        emit_idx = pix_q;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    state_d = ST_SCAN;
                    mode_d  = mode;
                    bg_d    = bg_color;
                    cx_d    = '0;
                    cy_d    = '0;
                    dep_d   = '0;
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                end
            end
            ST_SCAN: begin
                // Reads are pipelined: issue dep_q while judging the result for dep_q-1.
                if (pend_q && (rd_bit || dep_q == DEP_END)) begin
                    state_d  = ST_WRITE;
                    ram_d_d  = rd_bit ? shade(32'(dep_q) - 32'd1, 32'(GB)) : bg_q;
                    pix_d    = '0;
                    emit_idx = '0;
                    emit     = !display_on;
                end else begin
                    dep_d  = dep_q + 1'b1;
                    pend_d = 1'b1;
                end
            end
            ST_WRITE: begin
                if (pix_q == PIX_END) begin
                    dep_d  = '0;
                    pend_d = 1'b0;
                    if (cx_q == COL_MAX) begin
                        cx_d = '0;
                        if (cy_q == COL_MAX) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                            busy_d  = 1'b0;
                            rdy_d   = 1'b1;
                        end else begin
                            cy_d    = cy_q + 1'b1;
                            state_d = ST_SCAN;
                        end
                    end else begin
                        cx_d    = cx_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end else begin
                    emit = !display_on;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (emit) begin
            we_d   = 1'b1;
            addr_d = pix_addr(cx_q, cy_q, emit_idx);
            pix_d  = emit_idx + 1'b1;
        end
    end

    // State and output registers; reset drops everything back to an idle, write-free state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            bg_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            dep_q   <= '0;
            pend_q  <= 1'b0;
            pix_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ram_d_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            bg_q    <= bg_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            dep_q   <= dep_d;
            pend_q  <= pend_d;
            pix_q   <= pix_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ram_d_q <= ram_d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign we         = we_q;
    assign addr       = addr_q;
    assign ram_d      = ram_d_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign vox_ready  = rdy_q;

endmodule

// File: tb/tb_voxel_raster.sv
// Randomised self-checking bench for voxel_raster against a per-column projection model.
// Latency: n/a (testbench).
// Backpressure: display_on is driven as a pseudo-random stall source in one frame.
module tb_voxel_raster;

    logic        clk = 1'b0;
    logic        reset;
    logic        display_on;
    logic [8:0]  hpos, vpos;
    logic [1:0]  mode;
    logic [7:0]  bg_color;
    logic        vox_we;
    logic [8:0]  vox_addr;
    logic        vox_din;
    logic        vox_ready, we, busy, frame_done;
    logic [11:0] addr;
    logic [7:0]  ram_d;

    voxel_raster dut (
        .clk(clk), .reset(reset), .display_on(display_on), .hpos(hpos), .vpos(vpos),
        .mode(mode), .bg_color(bg_color), .vox_we(vox_we), .vox_addr(vox_addr),
        .vox_din(vox_din), .vox_ready(vox_ready), .we(we), .addr(addr), .ram_d(ram_d),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_mis = 0;
    bit          vm [512];             // model voxel bitmap, index x*64+y*8+z
    logic [19:0] exp_q [$];            // expected {addr, data} write stream
    logic [19:0] cap_q [$];            // captured {addr, data} write stream
    int          cyc = 0, last_we_cyc = 0, first_we_cyc = 0, done_cyc = 0, trig_cyc = 0;
    int          done_cnt = 0, stall_viol = 0;
    bit          prev_disp = 1'b0;
    int          poke_a [4] = '{0, 7*64+7*8, 3*64+3*8, 5*64+1*8};

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Observe outputs mid-cycle; the write decision uses display_on from the cycle before.
    always @(negedge clk) begin
        cyc++;
        if (we) begin
            if (cap_q.size() == 0) first_we_cyc = cyc;
            cap_q.push_back({addr, ram_d});
            last_we_cyc = cyc;
            if (prev_disp) stall_viol++;
        end
        if (frame_done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_disp = display_on;
    end

    function automatic int vidx(input logic [1:0] m, input int cx, input int cy, input int d);
        case (m)
            2'd1:    return cx*64 + d*8 + cy;
            2'd2:    return d*64 + cy*8 + cx;
            default: return cx*64 + cy*8 + d;
        endcase
    endfunction

    // Expected frame: per column find the nearest set voxel, then paint its block.
    task automatic build_expect(input logic [1:0] m, input logic [7:0] bg);
        exp_q.delete();
        for (int cy = 0; cy < 8; cy++) begin
            for (int cx = 0; cx < 8; cx++) begin
                int hit;
                logic [7:0] col;
                hit = -1;
                for (int d = 7; d >= 0; d--) if (vm[vidx(m, cx, cy, d)]) hit = d;
                col = (hit < 0) ? bg : 8'(255 - hit*32);
                for (int py = 0; py < 8; py++)
                    for (int px = 0; px < 8; px++)
                        exp_q.push_back({12'((cy*8 + py)*64 + cx*8 + px), col});
            end
        end
    endtask

    function automatic int find_pix(input int a);
        foreach (cap_q[i]) if (int'(cap_q[i][19:8]) == a) return int'(cap_q[i][7:0]);
        return -1;
    endfunction

    function automatic int count_val(input logic [7:0] v);
        int n;
        n = 0;
        foreach (cap_q[i]) if (cap_q[i][7:0] == v) n++;
        return n;
    endfunction

    task automatic vox_write(input int a, input bit v);
        vox_we = 1'b1; vox_addr = 9'(a); vox_din = v;
        @(posedge clk); #1;
        vox_we = 1'b0;
        vm[a] = v;
    endtask

    task automatic fire();
        vpos = 9'd240; hpos = 9'd0;
        @(posedge clk); #1;
        vpos = 9'd0; hpos = 9'd5;
        trig_cyc = cyc;
    endtask

    task automatic run_frame(input string tag, input logic [1:0] m, input logic [7:0] bg,
                             input bit stall, input bit poke);
        bit got;
        int mis;
        build_expect(m, bg);
        cap_q.delete(); done_cnt = 0; stall_viol = 0;
        mode = m; bg_color = bg; display_on = 1'b0;
        fire();
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_rdy_lo"}, vox_ready, 0);
        mode = ~m; bg_color = ~bg;     // latched values must be used, not live ones
        got = 1'b0;
        for (int n = 0; n < 30000 && !got; n++) begin
            if (stall) display_on = ($urandom_range(0, 3) == 0);
            if (n == 100) begin vpos = 9'd240; hpos = 9'd0; end
            else begin vpos = 9'd0; hpos = 9'd5; end
            if (poke && n >= 10 && n < 14) begin
                vox_we = 1'b1; vox_addr = 9'(poke_a[n-10]); vox_din = ~vm[poke_a[n-10]];
            end else vox_we = 1'b0;
            @(posedge clk); #1;
            if (done_cnt != 0) got = 1'b1;
        end
        display_on = 1'b0; vox_we = 1'b0; vpos = 9'd0; hpos = 9'd5;
        chk({tag, "_done_seen"}, got, 1);
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_count"}, cap_q.size(), 4096);
        mis = 0;
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) mis++;
        chk({tag, "_stream"}, mis, 0);
        chk({tag, "_stall_we"}, stall_viol, 0);
        chk({tag, "_pulses"}, done_cnt, 1);
        chk({tag, "_done_gap"}, done_cyc - last_we_cyc, 1);
        chk({tag, "_idle_busy"}, busy, 0);
        chk({tag, "_idle_rdy"}, vox_ready, 1);
    endtask

    initial begin
        reset = 1'b1; display_on = 1'b0; hpos = 9'd5; vpos = 9'd0; mode = 2'd0;
        bg_color = 8'h00; vox_we = 1'b0; vox_addr = '0; vox_din = 1'b0;
        foreach (vm[i]) vm[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", we, 0);
        chk("rst_addr", addr, 0);
        chk("rst_ram_d", ram_d, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_rdy", vox_ready, 1);
        reset = 1'b0;
        @(posedge clk); #1;

        // Front hit at depth 0: earliest possible first write.
        vox_write(0, 1'b1);
        run_frame("lat", 2'd0, 8'h00, 1'b0, 1'b0);
        chk("lat_first_we", first_we_cyc - trig_cyc, 3);
        chk("lat_px0", find_pix(0), 8'hFF);
        vox_write(0, 1'b0);

        run_frame("empty", 2'd0, 8'h12, 1'b0, 1'b0);
        chk("empty_all_bg", count_val(8'h12), 4096);

        vox_write(3*64 + 5*8 + 6, 1'b1);
        run_frame("front", 2'd0, 8'h12, 1'b0, 1'b0);
        chk("front_c0", find_pix(40*64 + 24), 8'h3F);
        chk("front_c1", find_pix(47*64 + 31), 8'h3F);
        chk("front_n", count_val(8'h3F), 64);
        run_frame("top", 2'd1, 8'h12, 1'b0, 1'b0);
        chk("top_c0", find_pix(48*64 + 24), 8'h5F);
        chk("top_n", count_val(8'h5F), 64);
        run_frame("side", 2'd2, 8'h12, 1'b0, 1'b0);
        chk("side_c0", find_pix(40*64 + 48), 8'h9F);
        chk("side_n", count_val(8'h9F), 64);
        vox_write(3*64 + 5*8 + 6, 1'b0);

        vox_write(2*64 + 2*8 + 2, 1'b1);
        vox_write(2*64 + 2*8 + 6, 1'b1);
        run_frame("occl", 2'd3, 8'h12, 1'b0, 1'b0);
        chk("occl_c0", find_pix(16*64 + 16), 8'hBF);
        chk("occl_no3f", count_val(8'h3F), 0);
        vox_write(2*64 + 2*8 + 2, 1'b0);
        vox_write(2*64 + 2*8 + 6, 1'b0);

        for (int a = 0; a < 512; a++) vox_write(a, $urandom_range(0, 3) == 0);
        for (int m = 1; m < 4; m++) run_frame($sformatf("rnd%0d", m), 2'(m), 8'($urandom), 1'b0, 1'b0);

        run_frame("stall", 2'd0, 8'($urandom), 1'b1, 1'b0);

        // Writes while busy are dropped; identical writes while idle take effect.
        run_frame("lock", 2'd0, 8'h21, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) vox_write(poke_a[k], ~vm[poke_a[k]]);
        run_frame("unlock", 2'd0, 8'h21, 1'b0, 1'b0);

        // Reset in the middle of a block write.
        cap_q.delete();
        mode = 2'd0; bg_color = 8'h33; display_on = 1'b0;
        fire();
        repeat (30) @(posedge clk);
        #1;
        chk("mid_we", we, 1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_we", we, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_ram_d", ram_d, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rdy", vox_ready, 1);
        chk("mid_rst_done", frame_done, 0);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        cap_q.delete();
        repeat (300) @(posedge clk);
        #1;
        chk("post_rst_quiet", cap_q.size(), 0);
        run_frame("post_rst", 2'd0, 8'h44, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/voxel_raster.md
# voxel_raster

Parametrised voxel-to-framebuffer renderer. Holds a GRID³ one-bit voxel bitmap, loadable through a side port. Once per frame it projects the grid orthographically along a selectable axis and writes depth-shaded CELL×CELL pixel blocks into the 8-bpp framebuffer RAM. Framebuffer writes happen only while `display_on` is low. The block sits beside the video sync generator and drives the framebuffer write port.

## Interface
- `GRID`, 8: voxels per axis; power of two, 2..16; `GB = log2(GRID)`.
- `CELL`, 8: screen pixels per voxel edge; power of two.
- `FB_W`, 64: framebuffer width in pixels; power of two.
- `ADDR_W`, 12: framebuffer address width. Requires `GRID*CELL <= FB_W` and `FB_W*GRID*CELL <= 2^ADDR_W`.
- `START_LINE`, 240: `vpos` value that triggers a frame.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: asynchronous, active-high.
- `display_on` in 1: high means active video, framebuffer busy.
- `hpos` in 9: horizontal beam position.
- `vpos` in 9: vertical beam position.
- `mode` in 2: view axis. 0 = front, 1 = top, 2 = side, 3 = front.
- `bg_color` in 8: colour for empty columns.
- `vox_we` in 1: voxel write strobe.
- `vox_addr` in 3·GB: voxel index `{x,y,z}`, x in the MSBs.
- `vox_din` in 1: voxel value.
- `vox_ready` out 1: high when voxel writes are accepted.
- `we` out 1: framebuffer write enable.
- `addr` out ADDR_W: framebuffer byte address.
- `ram_d` out 8: framebuffer write data.
- `busy` out 1: a render is in progress.
- `frame_done` out 1: one-cycle pulse at the end of a render.

## Operation
- States: IDLE, SCAN, WRITE, DONE.
- **IDLE → SCAN** when `vpos == START_LINE && hpos == 0`. On this transition:
  - latch `mode` and `bg_color`;
  - set column `(cx,cy) = (0,0)`;
  - `busy` = 1, `vox_ready` = 0.
  - Trigger conditions outside IDLE are ignored.
- **Column order:** raster order, `cy` outer, `cx` inner, both 0..GRID-1.
- **Mapping per column**, depth `d` = 0..GRID-1, 0 nearest:
  - front: voxel (cx, cy, d);
  - top: voxel (cx, d, cy);
  - side: voxel (d, cy, cx).
- **SCAN:**
  - issue one voxel read per cycle, d ascending;
  - stop at the first set voxel: colour = `8'hFF - (d << (8-GB))`, 8-bit;
  - if none is set: colour = latched `bg_color`;
  - go to WRITE;
  - SCAN does not depend on `display_on`.
- **WRITE:**
  - emit CELL×CELL pixels, row-major, pixel offset (px, py);
  - `addr = (cy*CELL+py)*FB_W + cx*CELL + px`, truncated to ADDR_W;
  - `ram_d` = column colour.
  - On a cycle with `display_on` = 0: `we` = 1 and the pixel counter advances.
  - On a cycle with `display_on` = 1: `we` = 0; counters and `addr` hold (stall).
  - After the last pixel: next column goes to SCAN; the last column goes to DONE.
- **DONE:** `frame_done` = 1 for one cycle, `busy` = 0, `vox_ready` = 1, return to IDLE.
- **Voxel port:**
  - write accepted when `vox_we && vox_ready`;
  - while busy, writes are dropped (no queue).
- **Reset,** including mid-render: immediately `we` = 0, `addr` = 0, `ram_d` = 0, `busy` = 0, `frame_done` = 0, `vox_ready` = 1, state IDLE.
  - Voxel contents are not cleared by reset; initial content is all zero.

## Timing
- All outputs are registered.
- Voxel read: synchronous, 1-cycle latency.
- SCAN costs hit depth + 2 cycles, or GRID + 1 cycles on a miss. This counts one cycle between the issue and evaluation of a read.
- First `we` comes at the earliest 3 cycles after the trigger cycle (front hit at d = 0).
- WRITE costs exactly CELL² cycles with `we` = 1, plus stall cycles.
- `frame_done` is asserted the cycle after the last `we`.
- A render may span several frames under stalls; no new trigger is taken until IDLE.
- Each frame writes exactly GRID²·CELL² bytes.

## Structure
- `voxel_pkg`:
  - mode encoding constants;
  - state enum;
  - shade function `(d, GB) → colour`.
- Sub-module `voxel_ram`:
  - GRID³ × 1 bitmap;
  - one write port and one synchronous read port;
  - zero-initialised.
- The FSM, column/pixel counters and address generation live in `voxel_raster`.

## Test plan
Defaults throughout (GRID = 8, CELL = 8, FB_W = 64).
- **Reset values:** assert `reset` mid-WRITE → same cycle `we` = 0, `addr` = 0, `busy` = 0, `vox_ready` = 1; no further writes until the next trigger.
- **Empty grid:** `bg_color` = 8'h12, `display_on` = 0, trigger → 4096 writes, all 8'h12, addresses 0..4095 each exactly once, then a one-cycle `frame_done`.
- **Single voxel (3,5,6):**
  - front: addresses (40+py)*64 + 24+px get 8'h3F;
  - top: cell (3,6) gets 8'h5F;
  - side: cell (6,5) gets 8'h9F;
  - all other addresses get bg.
- **Occlusion:** voxels (2,2,2) and (2,2,6), front → cell (2,2) gets 8'hBF only; no write of 8'h3F anywhere.
- **Stalls:** `display_on` toggled pseudo-randomly → `we` never high while `display_on` = 1; address sequence and 4096 total identical to the unstalled run.
- **Voxel port lockout:** `vox_we` pulses while busy → `vox_ready` = 0 and the next frame's output is unchanged. The same writes after `frame_done` → reflected in the next render.
